udp_rxframe_buffer: RTL and testbench

Ping-pong receive buffer between the UDP/IP receive core and the UDP command/parameter control stage. Captures each received UDP payload byte stream into one of two 2048-byte banks and presents one complete frame at a time. The downstream control stage sees a one-cycle done pulse, a byte count, a destination port and a random-access read port. Frames are dropped without stalling the receive core when they overflow, are empty, are flagged bad, or find both banks occupied.

---
 rtl/udp_rxframe_buffer.sv | 209 ++++++++++++++++++++
 tb/tb_udp_rxframe_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rxframe_buffer.sv
// rtl/udp_rxframe_buffer.sv - ping-pong UDP payload receive buffer with frame presentation handshake
// Optional destination-port acceptance filter: define UDP_RXBUF_PORT_FILTER_EN.
module udp_rxframe_buffer #(
    parameter int RAM_AW = 11,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_udp_rec_en,
    input  logic [7:0]        i_udp_rec_data,
    input  logic              i_udp_rec_pkt_done,
    input  logic              i_udp_rec_err,
    input  logic [15:0]       i_udp_rec_desport,
    input  logic [15:0]       i_local_port,
    output logic              o_udp_rxdone,
    input  logic              i_udp_rxram_rden,
    input  logic [RAM_AW-1:0] i_udp_rxram_rdaddr,
    output logic [7:0]        o_udp_rxram_data,
    output logic [15:0]       o_udp_rxbyte_num,
    output logic [15:0]       o_udprecv_desport,
    input  logic              i_rxbuf_release,
    output logic              o_rxbuf_busy,
    output logic [CNT_W-1:0]  o_frame_cnt,
    output logic [CNT_W-1:0]  o_drop_cnt
);
    localparam int DEPTH = 1 << RAM_AW;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_st_t;
    typedef enum logic [1:0] {R_IDLE, R_NOTIFY, R_BUSY} rd_st_t;

    wr_st_t            r_wst, w_wst_nxt;
    rd_st_t            r_rst_st, w_rst_nxt;
    logic [1:0]        r_full;
    logic              r_older;
    logic              r_wr_bank;
    logic [RAM_AW:0]   r_wr_cnt;
    logic              r_rd_bank;
    logic [15:0]       r_bank_cnt  [2];
    logic [15:0]       r_bank_port [2];
    logic [7:0]        r_ram       [2*DEPTH];
    logic [7:0]        r_rd_data;
    logic [15:0]       r_byte_num;
    logic [15:0]       r_desport;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_filter_ok;
    logic [1:0]        w_free;
    logic              w_any_free;
    logic              w_pick;
    logic              w_we;
    logic              w_wbank;
    logic [RAM_AW-1:0] w_waddr;
    logic [RAM_AW:0]   w_cnt_nxt;
    logic              w_commit;
    logic              w_drop;
    logic              w_ovf;
    logic              w_release;
    logic              w_rd_load;
    logic              w_rd_pick;
    logic              w_other;
    logic              w_other_full_nxt;

`ifdef UDP_RXBUF_PORT_FILTER_EN
    assign w_filter_ok = (i_udp_rec_desport == i_local_port);
`else
    logic w_unused_local_port;
    assign w_unused_local_port = ^i_local_port;
    assign w_filter_ok = 1'b1;
`endif

    // A bank being presented stays off-limits until released, even though full is also set.
    assign w_free[0]  = !r_full[0] && !(r_rst_st == R_BUSY && r_rd_bank == 1'b0);
    assign w_free[1]  = !r_full[1] && !(r_rst_st == R_BUSY && r_rd_bank == 1'b1);
    assign w_any_free = |w_free;
    assign w_pick     = !w_free[0];

    // Write FSM: state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_wst <= W_IDLE;
        else       r_wst <= w_wst_nxt;
    end

    // Write FSM: next state
    always_comb begin
        w_wst_nxt = r_wst;
        unique case (r_wst)
            W_IDLE: if (i_udp_rec_en && !i_udp_rec_pkt_done)
                        w_wst_nxt = w_any_free ? W_FILL : W_DROP;
            W_FILL: if (i_udp_rec_pkt_done) w_wst_nxt = W_IDLE;
                    else if (w_ovf)         w_wst_nxt = W_DROP;
            W_DROP: if (i_udp_rec_pkt_done) w_wst_nxt = W_IDLE;
            default: w_wst_nxt = W_IDLE;
        endcase
    end

    // Write FSM: outputs
    always_comb begin
        w_we      = 1'b0;
        w_wbank   = r_wr_bank;
        w_waddr   = '0;
        w_cnt_nxt = r_wr_cnt;
        w_commit  = 1'b0;
        w_drop    = 1'b0;
        w_ovf     = 1'b0;
        unique case (r_wst)
            W_IDLE: begin
                if (i_udp_rec_en && w_any_free) begin
                    w_we      = 1'b1;
                    w_wbank   = w_pick;
                    w_cnt_nxt = {{RAM_AW{1'b0}}, 1'b1};
                end
                if (i_udp_rec_pkt_done) begin
                    if (w_we && !i_udp_rec_err && w_filter_ok) w_commit = 1'b1;
                    else                                       w_drop   = 1'b1;
                end
            end
            W_FILL: begin
                w_ovf     = i_udp_rec_en && r_wr_cnt[RAM_AW];
                w_we      = i_udp_rec_en && !w_ovf;
                w_waddr   = r_wr_cnt[RAM_AW-1:0];
                w_cnt_nxt = r_wr_cnt + {{RAM_AW{1'b0}}, w_we};
                if (i_udp_rec_pkt_done) begin
                    if (!w_ovf && !i_udp_rec_err && w_filter_ok && w_cnt_nxt != '0)
                        w_commit = 1'b1;
                    else
                        w_drop   = 1'b1;
                end
            end
            W_DROP: w_drop = i_udp_rec_pkt_done;
            default: ;
        endcase
    end

    // Read FSM: state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_rst_st <= R_IDLE;
        else       r_rst_st <= w_rst_nxt;
    end

    // Read FSM: next state
    always_comb begin
        w_rst_nxt = r_rst_st;
        unique case (r_rst_st)
            R_IDLE:   if (|r_full) w_rst_nxt = R_NOTIFY;
            R_NOTIFY: w_rst_nxt = R_BUSY;
            R_BUSY:   if (i_rxbuf_release) w_rst_nxt = R_IDLE;
            default:  w_rst_nxt = R_IDLE;
        endcase
    end

    // Read FSM: outputs
    always_comb begin
        o_udp_rxdone = (r_rst_st == R_NOTIFY);
        o_rxbuf_busy = (r_rst_st == R_BUSY);
        w_release    = (r_rst_st == R_BUSY) && i_rxbuf_release;
        w_rd_load    = (r_rst_st == R_IDLE) && (|r_full);
        w_rd_pick    = (&r_full) ? r_older : !r_full[0];
    end

    assign w_other          = !w_wbank;
    assign w_other_full_nxt = r_full[w_other] && !(w_release && r_rd_bank == w_other);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full      <= 2'b00;
            r_older     <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_rd_bank   <= 1'b0;
            r_byte_num  <= '0;
            r_desport   <= '0;
            r_rd_data   <= '0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_wr_bank <= w_wbank;
            r_wr_cnt  <= w_cnt_nxt;
            if (w_release) r_full[r_rd_bank] <= 1'b0;
            if (w_commit) begin
                r_full[w_wbank] <= 1'b1;
                r_older         <= w_other_full_nxt ? w_other : w_wbank;
            end
            if (w_rd_load) begin
                r_rd_bank  <= w_rd_pick;
                r_byte_num <= r_bank_cnt[w_rd_pick];
                r_desport  <= r_bank_port[w_rd_pick];
            end
            if (i_udp_rxram_rden)
                r_rd_data <= r_ram[{r_rd_bank, i_udp_rxram_rdaddr}];
            if (w_commit && r_frame_cnt != {CNT_W{1'b1}}) r_frame_cnt <= r_frame_cnt + 1'b1;
            if (w_drop && r_drop_cnt != {CNT_W{1'b1}})    r_drop_cnt  <= r_drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we) r_ram[{w_wbank, w_waddr}] <= i_udp_rec_data;
        if (w_commit) begin
            r_bank_cnt[w_wbank]  <= 16'(w_cnt_nxt);
            r_bank_port[w_wbank] <= i_udp_rec_desport;
        end
    end

    assign o_udp_rxram_data  = r_rd_data;
    assign o_udp_rxbyte_num  = r_byte_num;
    assign o_udprecv_desport = r_desport;
    assign o_frame_cnt       = r_frame_cnt;
    assign o_drop_cnt        = r_drop_cnt;
endmodule

// File: tb/tb_udp_rxframe_buffer.sv
// tb/tb_udp_rxframe_buffer.sv - scoreboard bench for udp_rxframe_buffer
module tb_udp_rxframe_buffer;
    localparam int RAM_AW = 11;
    localparam int CNT_W  = 16;

    typedef struct {
        int         len;
        logic [7:0] base;
        logic [15:0] port;
    } frame_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              rec_en, pkt_done, rec_err;
    logic [7:0]        rec_data;
    logic [15:0]       rec_port, local_port;
    logic              rxdone, rden, release_in, busy;
    logic [RAM_AW-1:0] rdaddr;
    logic [7:0]        rd_data;
    logic [15:0]       byte_num, desport;
    logic [CNT_W-1:0]  frame_cnt, drop_cnt;

    always #5 clk = ~clk;

    udp_rxframe_buffer #(.RAM_AW(RAM_AW), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_udp_rec_en(rec_en), .i_udp_rec_data(rec_data),
        .i_udp_rec_pkt_done(pkt_done), .i_udp_rec_err(rec_err),
        .i_udp_rec_desport(rec_port), .i_local_port(local_port),
        .o_udp_rxdone(rxdone), .i_udp_rxram_rden(rden),
        .i_udp_rxram_rdaddr(rdaddr), .o_udp_rxram_data(rd_data),
        .o_udp_rxbyte_num(byte_num), .o_udprecv_desport(desport),
        .i_rxbuf_release(release_in), .o_rxbuf_busy(busy),
        .o_frame_cnt(frame_cnt), .o_drop_cnt(drop_cnt)
    );

    int     n_tests = 0, n_fail = 0;
    int     cyc = 0;
    int     exp_rx_cyc = -1;
    int     rx_pulses = 0, exp_pulses = 0;
    int     exp_frames = 0, exp_drops = 0;
    logic   prev_rxdone = 1'b0;
    frame_t sb[$];
    frame_t cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pop the scoreboard whenever a frame is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rxdone) begin
                rx_pulses++;
                check("rx_width", 32'(prev_rxdone), 32'd0);
                check("rx_sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                    check("rx_bytes", 32'(byte_num), 32'(cur.len));
                    check("rx_port", 32'(desport), 32'(cur.port));
                    if (exp_rx_cyc >= 0) begin
                        check("rx_latency", 32'(cyc), 32'(exp_rx_cyc));
                        exp_rx_cyc = -1;
                    end
                end
            end
            prev_rxdone = rxdone;
        end
    end

    task automatic push(input int len, input logic [7:0] base, input logic [15:0] port);
        frame_t f;
        f.len = len; f.base = base; f.port = port;
        sb.push_back(f);
        exp_pulses++;
        exp_frames++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int len, input logic [7:0] base, input logic [15:0] port,
                              input logic [15:0] lport, input logic err, input logic chk,
                              input logic rel);
        rec_port   = port;
        local_port = lport;
        for (int i = 0; i < len; i++) begin
            rec_en   = 1'b1;
            rec_data = base + 8'(i);
            if (i == len - 1) begin
                pkt_done   = 1'b1;
                rec_err    = err;
                release_in = rel;
                if (chk) exp_rx_cyc = cyc + 2;
            end
            @(posedge clk); #1;
        end
        if (len == 0) begin
            pkt_done   = 1'b1;
            rec_err    = err;
            release_in = rel;
            @(posedge clk); #1;
        end
        rec_en = 1'b0; pkt_done = 1'b0; rec_err = 1'b0; release_in = 1'b0;
    endtask

    task automatic wait_rx(input int target);
        for (int k = 0; k < 200 && rx_pulses < target; k++) begin @(posedge clk); #1; end
        check("rx_count", 32'(rx_pulses), 32'(target));
    endtask

    task automatic read_frame();
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < cur.len; i++) begin
            rden   = 1'b1;
            rdaddr = RAM_AW'(i);
            e      = cur.base + 8'(i);
            @(posedge clk); #1;
            check("rd_data", 32'(rd_data), 32'(e));
        end
        rden = 1'b0; rdaddr = '0;
        @(posedge clk); #1;
        check("rd_hold", 32'(rd_data), 32'(e));
    endtask

    task automatic release_buf(input logic chk);
        release_in = 1'b1;
        if (chk) exp_rx_cyc = cyc + 2;
        @(posedge clk); #1;
        release_in = 1'b0;
    endtask

    task automatic check_cnts();
        check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
    endtask

    initial begin
        rst = 1'b1; rec_en = 1'b0; pkt_done = 1'b0; rec_err = 1'b0; rec_data = '0;
        rec_port = '0; local_port = '0; rden = 1'b0; rdaddr = '0; release_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_rxdone", 32'(rxdone), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_bytenum", 32'(byte_num), 32'd0);
        check("rst_port", 32'(desport), 32'd0);
        check_cnts();

        // single 64-byte frame
        push(64, 8'h00, 16'h0BB8);
        send_frame(64, 8'h00, 16'h0BB8, 16'h0BB8, 1'b0, 1'b1, 1'b0);
        wait_rx(exp_pulses);
        check("busy_presented", 32'(busy), 32'd1);
        read_frame();
        check_cnts();
        release_buf(1'b0);
        idle(2);
        check("busy_released", 32'(busy), 32'd0);

        // three back-to-back frames, third finds both banks occupied
        push(10, 8'h40, 16'h1001);
        push(10, 8'h50, 16'h1002);
        exp_pulses = exp_pulses - 1;
        send_frame(10, 8'h40, 16'h1001, 16'h1001, 1'b0, 1'b1, 1'b0);
        send_frame(10, 8'h50, 16'h1002, 16'h1002, 1'b0, 1'b0, 1'b0);
        send_frame(10, 8'h60, 16'h1003, 16'h1003, 1'b0, 1'b0, 1'b0);
        exp_drops++;
        wait_rx(exp_pulses);
        read_frame();
        check_cnts();
        exp_pulses++;
        release_buf(1'b1);
        wait_rx(exp_pulses);
        read_frame();
        release_buf(1'b0);
        idle(3);

        // overflow then a short frame
        send_frame(2050, 8'h11, 16'h2000, 16'h2000, 1'b0, 1'b0, 1'b0);
        exp_drops++;
        idle(4);
        check("no_rx_ovf", 32'(rx_pulses), 32'(exp_pulses));
        push(8, 8'h80, 16'h2001);
        send_frame(8, 8'h80, 16'h2001, 16'h2001, 1'b0, 1'b1, 1'b0);
        wait_rx(exp_pulses);
        read_frame();
        check_cnts();
        release_buf(1'b0);
        idle(2);

        // error frame and empty frame
        send_frame(20, 8'h90, 16'h3000, 16'h3000, 1'b1, 1'b0, 1'b0);
        send_frame(0, 8'h00, 16'h3001, 16'h3001, 1'b0, 1'b0, 1'b0);
        exp_drops += 2;
        idle(4);
        check("no_rx_err", 32'(rx_pulses), 32'(exp_pulses));
        check_cnts();

        // commit coinciding with release, then zero-gap frame into the freed bank
        push(12, 8'hA0, 16'h4000);
        send_frame(12, 8'hA0, 16'h4000, 16'h4000, 1'b0, 1'b1, 1'b0);
        wait_rx(exp_pulses);
        read_frame();
        push(16, 8'hB0, 16'h4001);
        push(9, 8'hC0, 16'h4002);
        exp_pulses = exp_pulses - 1;
        send_frame(16, 8'hB0, 16'h4001, 16'h4001, 1'b0, 1'b1, 1'b1);
        send_frame(9, 8'hC0, 16'h4002, 16'h4002, 1'b0, 1'b0, 1'b0);
        wait_rx(exp_pulses);
        read_frame();
        check_cnts();
        exp_pulses++;
        release_buf(1'b1);
        wait_rx(exp_pulses);
        read_frame();
        release_buf(1'b0);
        idle(3);

        // destination port filter
`ifdef UDP_RXBUF_PORT_FILTER_EN
        send_frame(14, 8'hD0, 16'h1F90, 16'h0BB8, 1'b0, 1'b0, 1'b0);
        exp_drops++;
        idle(4);
        check("no_rx_filter", 32'(rx_pulses), 32'(exp_pulses));
`else
        push(14, 8'hD0, 16'h1F90);
        send_frame(14, 8'hD0, 16'h1F90, 16'h0BB8, 1'b0, 1'b1, 1'b0);
        wait_rx(exp_pulses);
        read_frame();
        release_buf(1'b0);
        idle(2);
`endif
        check_cnts();

        // reset in the middle of a frame while another is presented
        push(5, 8'hE0, 16'h5000);
        send_frame(5, 8'hE0, 16'h5000, 16'h5000, 1'b0, 1'b1, 1'b0);
        wait_rx(exp_pulses);
        for (int i = 0; i < 5; i++) begin
            rec_en = 1'b1; rec_data = 8'(i);
            @(posedge clk); #1;
        end
        rec_en = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        sb.delete();
        exp_frames = 0; exp_drops = 0; exp_rx_cyc = -1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_bytenum", 32'(byte_num), 32'd0);
        check_cnts();
        push(6, 8'hF0, 16'h5001);
        send_frame(6, 8'hF0, 16'h5001, 16'h5001, 1'b0, 1'b1, 1'b0);
        wait_rx(exp_pulses);
        read_frame();
        check_cnts();
        release_buf(1'b0);
        idle(4);
        check("rx_total", 32'(rx_pulses), 32'(exp_pulses));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
